csa_accumulator: RTL and testbench

//   Parametrised, sequential successor to the 3-operand carry-save adder.
//   - Accepts a stream of WIDTH-bit operands over a valid/ready handshake.
//   - Compresses each operand into a redundant sum/carry pair (3:2 CSA per beat), so there is no carry chain in the loop.
//   - On the packet's last beat, resolves sum+carry with one carry-propagate add.
//   - Presents the total and beat count over an output valid/ready handshake.
//   - Sits between operand producers and consumers of multi-operand sums (dot-product / popcount style datapaths).

---
 rtl/csa_accumulator.sv | 182 ++++++++++++++++++
 tb/tb_csa_accumulator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - streaming multi-operand accumulator built on a 3:2 carry-save loop
//
// Purpose
//   Sums a packet of WIDTH-bit operands delivered over a valid/ready stream.
//   Each accepted beat is folded into a redundant sum/carry pair with a 3:2
//   compressor, so the per-beat loop has no carry chain. After the packet's
//   last beat, one resolve cycle runs a single carry-propagate add. The total
//   and the beat count are then offered on an output valid/ready handshake.
//
// Parameters
//   WIDTH   operand width in bits
//   ACC_W   accumulator/result width in bits (ACC_W >= WIDTH, ACC_W >= 2)
//   CNT_W   beat-counter width in bits
//   SIGNED  1: operands sign-extended to ACC_W, 0: zero-extended
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block can accept a beat (ACCUM state)
//   in_data    in   WIDTH  operand
//   in_last    in   1      beat is the final operand of its packet
//   out_valid  out  1      result valid (OUTPUT state)
//   out_ready  in   1      consumer accepts the result
//   out_sum    out  ACC_W  packet total modulo 2^ACC_W
//   out_count  out  CNT_W  beats in the packet, saturating at 2^CNT_W-1

module csa_accumulator #(
    parameter int WIDTH  = 6,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Redundant accumulator: the running total is s_q + c_q (mod 2^ACC_W).
    logic [ACC_W-1:0] s_q, s_d;
    logic [ACC_W-1:0] c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Resolved result registers; they keep their value after hand-off.
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ACC_W-1:0] x_ext;
    logic [ACC_W-1:0] maj;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat_acc;

    // Operand extension. Bits above the operand replicate its MSB when
    // SIGNED, otherwise they are zero. Written per bit so ACC_W == WIDTH
    // needs no zero-width replication.
    for (genvar i = 0; i < ACC_W; i++) begin : g_ext
        if (i < WIDTH) begin : g_bit
            assign x_ext[i] = in_data[i];
        end else begin : g_pad
            assign x_ext[i] = SIGNED ? in_data[WIDTH-1] : 1'b0;
        end
    end

    // 3:2 compressor: majority bits become the carry word, shifted one place
    // left. The bit shifted out of the top is weight 2^ACC_W and is
    // discarded, which is exactly the modulo wrap of the result.
    assign maj = (s_q & c_q) | (s_q & x_ext) | (c_q & x_ext);

    // Saturating beat counter: holds at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // Handshake outputs decode the state only, so there is no combinational
    // path from in_valid or out_ready to in_ready or out_valid.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_OUTPUT);
    assign beat_acc  = in_valid && in_ready;

    assign out_sum   = sum_q;
    assign out_count = count_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: begin
                if (beat_acc && in_last) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // Datapath next-state logic
    always_comb begin
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        count_d = count_q;
        case (state_q)
            ST_ACCUM: begin
                if (beat_acc) begin
                    s_d   = s_q ^ c_q ^ x_ext;
                    c_d   = {maj[ACC_W-2:0], 1'b0};
                    cnt_d = cnt_inc;
                end
            end
            ST_RESOLVE: begin
                // The only carry-propagate add in the block.
                sum_d   = s_q + c_q;
                count_d = cnt_q;
            end
            ST_OUTPUT: begin
                // Clear the accumulator as the result is taken so the next
                // packet starts from zero.
                if (out_ready) begin
                    s_d   = '0;
                    c_d   = '0;
                    cnt_d = '0;
                end
            end
            default: begin
                s_d   = '0;
                c_d   = '0;
                cnt_d = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset drops any partial packet and pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
        end else begin
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - self-checking bench for csa_accumulator

module tb_csa_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] in_data;
    logic       in_last;
    logic       out_ready;

    // u16: WIDTH=6 ACC_W=16 unsigned; s16: signed; u8: ACC_W=8 unsigned.
    // All three share the stimulus, so their handshakes move in lockstep.
    logic        in_ready0, out_valid0;
    logic [15:0] out_sum0;
    logic [7:0]  out_count0;
    logic        in_ready1, out_valid1;
    logic [15:0] out_sum1;
    logic [7:0]  out_count1;
    logic        in_ready2, out_valid2;
    logic [7:0]  out_sum2;
    logic [7:0]  out_count2;

    int total = 0;
    int bad   = 0;

    csa_accumulator #(.WIDTH(6), .ACC_W(16), .CNT_W(8), .SIGNED(1'b0)) u_u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
        .out_ready(out_ready), .out_sum(out_sum0), .out_count(out_count0)
    );

    csa_accumulator #(.WIDTH(6), .ACC_W(16), .CNT_W(8), .SIGNED(1'b1)) u_s16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
        .out_ready(out_ready), .out_sum(out_sum1), .out_count(out_count1)
    );

    csa_accumulator #(.WIDTH(6), .ACC_W(8), .CNT_W(8), .SIGNED(1'b0)) u_u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_sum(out_sum2), .out_count(out_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              n;
        logic [9:0][5:0] ops;   // ops[0] is the first beat
        logic [15:0]     e_u16;
        logic [15:0]     e_s16;
        logic [7:0]      e_u8;
        logic [7:0]      e_cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [7:0] e2, input logic [7:0] ec);
        chk({nm, "_sum_u16"}, 32'(out_sum0), 32'(e0));
        chk({nm, "_sum_s16"}, 32'(out_sum1), 32'(e1));
        chk({nm, "_sum_u8"},  32'(out_sum2), 32'(e2));
        chk({nm, "_cnt_u16"}, 32'(out_count0), 32'(ec));
        chk({nm, "_cnt_s16"}, 32'(out_count1), 32'(ec));
        chk({nm, "_cnt_u8"},  32'(out_count2), 32'(ec));
    endtask

    // Presents one beat and returns 1 time unit after the edge that took it.
    task automatic send_beat(input logic [5:0] d, input logic last);
        int budget;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        budget   = 0;
        @(negedge clk);
        while (!in_ready0 && budget < 50) begin
            budget++;
            @(negedge clk);
        end
        if (!in_ready0) begin
            chk("send_beat_timeout", 32'(in_ready0), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 6'h00;
        in_last  = 1'b0;
    endtask

    // Waits (bounded) for out_valid, checks the result, lets it be taken.
    task automatic wait_result(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                               input logic [7:0] e2, input logic [7:0] ec);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!out_valid0 && budget < 20) begin
            budget++;
            @(negedge clk);
        end
        chk({nm, "_valid"}, 32'(out_valid0), 32'd1);
        chk_all(nm, e0, e1, e2, ec);
        @(posedge clk);
        #1;
    endtask

    // Table packet with the exact cycle timing around the last beat.
    task automatic run_vec(input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        for (int b = 0; b < vecs[idx].n; b++) begin
            send_beat(vecs[idx].ops[b], b == vecs[idx].n - 1);
        end
        @(negedge clk);   // resolve cycle
        chk({nm, "_resolve_valid"}, 32'(out_valid0), 32'd0);
        chk({nm, "_resolve_ready"}, 32'(in_ready0), 32'd0);
        @(negedge clk);   // output cycle
        chk({nm, "_out_valid"}, 32'(out_valid0), 32'd1);
        chk({nm, "_out_ready"}, 32'(in_ready0), 32'd0);
        chk_all(nm, vecs[idx].e_u16, vecs[idx].e_s16, vecs[idx].e_u8, vecs[idx].e_cnt);
        @(negedge clk);   // result taken, back to accumulating
        chk({nm, "_back_valid"}, 32'(out_valid0), 32'd0);
        chk({nm, "_back_ready"}, 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the randomized phase
    logic        rnd_on = 1'b0;
    int          rnd_pkts = 0;
    logic [15:0] m0 = '0, m1 = '0;
    logic [7:0]  m2 = '0, mc = '0;
    logic [15:0] p0 = '0, p1 = '0;
    logic [7:0]  p2 = '0, pc = '0;

    always @(negedge clk) begin
        if (rnd_on && rst_n) begin
            if (in_valid && in_ready0) begin
                m0 = m0 + {10'd0, in_data};
                m1 = m1 + {{10{in_data[5]}}, in_data};
                m2 = m2 + {2'd0, in_data};
                if (mc != 8'hFF) mc = mc + 8'd1;
                if (in_last) begin
                    p0 = m0; p1 = m1; p2 = m2; pc = mc;
                    m0 = '0; m1 = '0; m2 = '0; mc = '0;
                end
            end
            if (out_valid0 && out_ready) begin
                chk_all("rnd", p0, p1, p2, pc);
                rnd_pkts++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3,  {42'd0, 6'd20, 6'd25, 6'd40},                 16'h0055, 16'h0015, 8'h55, 8'd3};
        vecs[1] = '{1,  {54'd0, 6'd63},                                16'h003F, 16'hFFFF, 8'h3F, 8'd1};
        vecs[2] = '{3,  {42'd0, 6'h05, 6'h20, 6'h3F},                 16'h0064, 16'hFFE4, 8'h64, 8'd3};
        vecs[3] = '{10, {10{6'd63}},                                   16'h0276, 16'hFFF6, 8'h76, 8'd10};
        vecs[4] = '{4,  {36'd0, 6'd8, 6'd4, 6'd2, 6'd1},              16'h000F, 16'h000F, 8'h0F, 8'd4};
        vecs[5] = '{2,  {48'd0, 6'h20, 6'h1F},                        16'h003F, 16'hFFFF, 8'h3F, 8'd2};
        vecs[6] = '{4,  {36'd0, 6'h01, 6'h3F, 6'h15, 6'h2A},          16'h007F, 16'hFFFF, 8'h7F, 8'd4};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 6'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready",  32'(in_ready0),  32'd1);
        chk("reset_out_valid", 32'(out_valid0), 32'd0);
        chk("reset_in_ready_s", 32'(in_ready1), 32'd1);
        chk("reset_out_valid_u8", 32'(out_valid2), 32'd0);
        chk_all("reset", 16'h0, 16'h0, 8'h0, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_vec(i);
        end

        // Backpressure: result held 5 cycles, then the next packet's first
        // beat is accepted in the cycle after the result is taken.
        out_ready = 1'b0;
        send_beat(6'd3, 1'b0);
        send_beat(6'd4, 1'b1);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(out_valid0), 32'd1);
            chk("bp_in_ready", 32'(in_ready0), 32'd0);
            chk("bp_sum", 32'(out_sum0), 32'd7);
            chk("bp_count", 32'(out_count0), 32'd2);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 6'd5;
        in_last   = 1'b1;
        @(negedge clk);
        chk("bp_take_valid", 32'(out_valid0), 32'd1);
        chk("bp_take_in_ready", 32'(in_ready0), 32'd0);
        @(negedge clk);
        chk("bp_after_in_ready", 32'(in_ready0), 32'd1);
        chk("bp_after_valid", 32'(out_valid0), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("bp_next_resolve_ready", 32'(in_ready0), 32'd0);
        @(negedge clk);
        chk("bp_next_valid", 32'(out_valid0), 32'd1);
        chk_all("bp_next", 16'd5, 16'd5, 8'd5, 8'd1);
        @(posedge clk);
        #1;

        // Reset mid-packet discards the partial sum and the held result.
        send_beat(6'd7, 1'b0);
        send_beat(6'd9, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready0), 32'd1);
        chk("rst_mid_out_valid", 32'(out_valid0), 32'd0);
        chk_all("rst_mid", 16'h0, 16'h0, 8'h0, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int b = 0; b < 4; b++) begin
            send_beat(6'd1, b == 3);
        end
        wait_result("post_rst", 16'd4, 16'd4, 8'd4, 8'd4);

        // Counter saturation: 300 beats of 1.
        for (int b = 0; b < 300; b++) begin
            send_beat(6'd1, b == 299);
        end
        wait_result("sat", 16'd300, 16'd300, 8'd44, 8'd255);

        // out_ready high while idle has no effect.
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_out_valid", 32'(out_valid0), 32'd0);
        chk("idle_in_ready", 32'(in_ready0), 32'd1);

        // Randomized stream against the scoreboard.
        rnd_on = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 6'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rnd_on = 1'b0;
        chk("rnd_packets_seen", 32'(rnd_pkts >= 20), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
